address_encoder: RTL
====================

# address_encoder

Sequential 16-to-4 address encoder: inverse of the 4-bit predecode stage. It captures a 16-bit multi-hot line vector, such as word-line hits or match lines from a memory array, and serialises it into a stream of 4-bit line addresses, one per accepted handshake. Each served line is cleared until none remain. It sits between array-side line outputs and any consumer that needs binary indices.

## Interface
Parameters:
- HIGH_FIRST, default 0: 0 serves the lowest set index first; 1 serves the highest set index first.

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset_n  input  1  synchronous reset, active-low
- load_valid  input  1  a line vector is offered on load_lines
- load_ready  output  1  block can accept a vector (high only in IDLE)
- load_lines  input  16  multi-hot line vector; bit i is line i
- address_valid  output  1  encoded_address holds a pending line index
- address_ready  input  1  consumer accepts encoded_address this cycle
- encoded_address  output  4  binary index of the line currently being served
- address_last  output  1  the current address is the final pending line
- match_count  output  5  popcount of the last accepted vector, 0..16
- none_found  output  1  one-cycle pulse: the accepted vector was all zeros

## Operation
- State: 2-state FSM {IDLE, DRAIN}, a 16-bit pending register and a 5-bit match_count register.
- IDLE:
  - load_ready=1.
  - On load_valid=1: pending<=load_lines and match_count<=popcount(load_lines).
  - If load_lines!=0, go to DRAIN. Otherwise stay in IDLE and assert none_found for the next cycle.
- DRAIN:
  - load_ready=0, and load_valid is ignored.
  - address_valid=1.
  - encoded_address = index of the lowest set bit of pending, or the highest if HIGH_FIRST=1.
  - address_last=1 when exactly one bit of pending is set.
  - On address_ready=1: clear the pending bit at encoded_address.
  - If address_last=1 at the same time, go to IDLE.
- match_count holds its value until the next accepted load. It is not decremented as lines drain.
- encoded_address, address_valid and address_last are combinational functions of registered state only. There is no input-to-output combinational path.
- In IDLE: address_valid=0, address_last=0, encoded_address=0.
- Every vector produces exactly popcount(load_lines) address transfers with distinct, strictly monotonic indices (ascending, or descending when HIGH_FIRST=1).

## Timing
- Reset (reset_n=0 at an edge): state=IDLE, pending=0, match_count=0, none_found=0. Consequently load_ready=1, address_valid=0, encoded_address=0, address_last=0.
- Reset during DRAIN aborts the drain. No further addresses are emitted.
- Load accepted at edge N: address_valid=1 from cycle N+1. The first address is available one cycle after the load.
- Throughput is one address per cycle while address_ready is held at 1.
- A vector with k set bits, with address_ready held at 1, drains in k cycles. load_ready returns to 1 in the cycle after the last transfer.
- address_ready=0 stalls the block. encoded_address, address_last and pending hold stable, and address_valid stays 1 (no retraction).
- All-zero load: the block stays in IDLE. none_found=1 for exactly one cycle (N+1), match_count=0, and address_valid never rises. A new load may be accepted in cycle N+1.
- Full vector 16'hFFFF: match_count=16 (5-bit, no wrap). Sixteen transfers, 0..15, with address_last only on index 15 (or on index 0 when HIGH_FIRST=1).
- address_ready while in IDLE has no effect.

## Test plan
- Reset then single line: load 16'h0100 -> next cycle address_valid=1, encoded_address=8, address_last=1, match_count=1. Accept -> IDLE, load_ready=1.
- Multi-hot with HIGH_FIRST=0: load 16'h8421, address_ready=1 -> addresses 0,5,10,15 on consecutive cycles, address_last only with 15, match_count=4. Repeat with HIGH_FIRST=1 -> 15,10,5,0.
- Backpressure: load 16'h0006, address_ready=0 for 3 cycles -> encoded_address stays 1, address_valid stays 1. Then address_ready=1 -> 1 then 2. A load_valid asserted during the drain is not accepted.
- Empty vector: load 16'h0000 -> none_found=1 for one cycle, match_count=0, address_valid=0. Immediately load 16'h0001 -> address 0 follows.
- Full vector: load 16'hFFFF -> match_count=16, sixteen transfers 0..15, load_ready high the cycle after the last transfer.
- Reset mid-drain: load 16'hF000, accept address 12, then assert reset_n=0 for one edge -> address_valid=0, load_ready=1, match_count=0. No addresses 13..15 appear.

Source files
------------

// File: rtl/address_encoder.sv
// address_encoder: captures a 16-bit multi-hot line vector and serialises it
// into a stream of 4-bit line indices, one per accepted handshake.
//
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   load_valid/load_ready   vector handshake (ready only while idle)
//   load_lines[15:0]        multi-hot line vector, bit i is line i
//   address_valid/ready     index handshake (valid only while draining)
//   encoded_address[3:0]    index of the line currently being served
//   address_last            current index is the final pending line
//   match_count[4:0]        popcount of the last accepted vector
//   none_found              one-cycle pulse after an all-zero load
module address_encoder #(
    parameter int unsigned HIGH_FIRST = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_lines,
    output logic        address_valid,
    input  logic        address_ready,
    output logic [3:0]  encoded_address,
    output logic        address_last,
    output logic [4:0]  match_count,
    output logic        none_found
);

    localparam int unsigned LINES = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = 5;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [LINES-1:0] r_pending;
    logic [LINES-1:0] w_pending_next;
    logic [CW-1:0]    r_match_count;
    logic [CW-1:0]    w_match_next;
    logic             r_none_found;
    logic             w_none_next;

    logic [AW-1:0]    w_index;
    logic             w_single;
    logic [CW-1:0]    w_popcount;

    // Population count of the offered vector.
    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < LINES; i++) begin
            w_popcount = w_popcount + CW'(load_lines[i]);
        end
    end

    // Priority select over pending lines; the last match in loop order wins.
    always_comb begin
        w_index = '0;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < LINES; i++) begin
                if (r_pending[i]) w_index = AW'(i);
            end
        end else begin
            for (int i = LINES - 1; i >= 0; i--) begin
                if (r_pending[i]) w_index = AW'(i);
            end
        end
    end

    // Exactly one pending bit: non-zero and clearing the lowest set bit leaves zero.
    assign w_single = (r_pending != '0) &&
                      ((r_pending & (r_pending - 16'd1)) == '0);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_match_count <= '0;
            r_none_found  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pending     <= w_pending_next;
            r_match_count <= w_match_next;
            r_none_found  <= w_none_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_match_next   = r_match_count;
        w_none_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_pending_next = load_lines;
                    w_match_next   = w_popcount;
                    if (load_lines != '0) begin
                        w_state_next = S_DRAIN;
                    end else begin
                        w_none_next = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (address_ready) begin
                    w_pending_next = r_pending & ~(16'd1 << w_index);
                    if (w_single) w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only.
    assign load_ready      = (r_state == S_IDLE);
    assign address_valid   = (r_state == S_DRAIN);
    assign encoded_address = address_valid ? w_index : '0;
    assign address_last    = address_valid && w_single;
    assign match_count     = r_match_count;
    assign none_found      = r_none_found;

endmodule
